// File: rtl/note_scheduler_pkg.sv
// Shared definitions for the note scheduler: key count, index width and FSM state encoding.
package note_scheduler_pkg;
  localparam int NKEYS = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MONO = 2'd1,
    ARP  = 2'd2,
    MUTE = 2'd3
  } state_t;
endpackage

// File: rtl/key_priority_pick.sv
// Combinational key picker: highest set bit (mode 0) or the next set bit above cur,
// wrapping to the lowest set bit (mode 1).
module key_priority_pick
  import note_scheduler_pkg::*;
(
  input  logic [NKEYS-1:0] mask,
  input  logic [IDX_W-1:0] cur,
  input  logic             mode,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] nx_idx;
  logic             nx_found;

  // Descending scan so the last hit is the smallest qualifying index.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    nx_idx   = '0;
    nx_found = 1'b0;
    for (int i = 0; i < NKEYS; i++) begin
      if (mask[i]) hi_idx = IDX_W'(i);
    end
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (mask[i]) lo_idx = IDX_W'(i);
      if (mask[i] && (i > int'(cur))) begin
        nx_idx   = IDX_W'(i);
        nx_found = 1'b1;
      end
    end
    idx = mode ? (nx_found ? nx_idx : lo_idx) : hi_idx;
  end

  assign any = |mask;

endmodule

// File: rtl/note_scheduler.sv
// Picks the single sounding piano key for the tone generator (MONO last-pressed or
// timed ARP cycle) and drives the Pmod amplifier control pins.
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter int   ARP_DIV  = 25_000_000,
  parameter logic GAIN_LVL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             play,
  input  logic             arp_mode,
  input  logic [NKEYS-1:0] keys,
  output logic [IDX_W-1:0] note_idx,
  output logic             note_valid,
  output logic             note_start,
  output logic             amp_shutdown_n,
  output logic             amp_gain
);

  localparam int               CNT_W      = $clog2(ARP_DIV);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(ARP_DIV - 1);

  state_t           state;
  logic [NKEYS-1:0] keys_q;
  logic [CNT_W-1:0] arp_cnt;

  logic [NKEYS-1:0] press;
  logic             press_any;
  logic [NKEYS-1:0] hi_mask;
  logic [IDX_W-1:0] hi_idx;
  logic             hi_any;
  logic [IDX_W-1:0] nx_idx;
  logic             held_any;
  logic             owner_rel;
  logic             mode_mismatch;

  assign press     = keys & ~keys_q;
  assign press_any = |press;

  // Leaving MUTE treats every held key as freshly pressed, so pick from held there.
  assign hi_mask = (state == MUTE) ? keys : (press_any ? press : keys);

  key_priority_pick u_pick_hi (
    .mask (hi_mask),
    .cur  (note_idx),
    .mode (1'b0),
    .idx  (hi_idx),
    .any  (hi_any)
  );

  key_priority_pick u_pick_next (
    .mask (keys),
    .cur  (note_idx),
    .mode (1'b1),
    .idx  (nx_idx),
    .any  (held_any)
  );

  assign owner_rel     = note_valid && !keys[note_idx];
  assign mode_mismatch = arp_mode != (state == ARP);
  assign amp_gain      = GAIN_LVL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keys_q         <= '0;
      state          <= IDLE;
      note_idx       <= '0;
      note_valid     <= 1'b0;
      note_start     <= 1'b0;
      amp_shutdown_n <= 1'b0;
      arp_cnt        <= CNT_RELOAD;
    end else begin
      keys_q     <= keys;
      note_start <= 1'b0;
      if (!play) begin
        state          <= MUTE;
        note_valid     <= 1'b0;
        amp_shutdown_n <= 1'b0;
      end else begin
        amp_shutdown_n <= 1'b1;
        case (state)
          MUTE: begin
            if (hi_any) begin
              state      <= arp_mode ? ARP : MONO;
              note_idx   <= hi_idx;
              note_valid <= 1'b1;
              note_start <= 1'b1;
              arp_cnt    <= CNT_RELOAD;
            end else begin
              state <= IDLE;
            end
          end
          IDLE: begin
            if (press_any) begin
              state      <= arp_mode ? ARP : MONO;
              note_idx   <= hi_idx;
              note_valid <= 1'b1;
              note_start <= 1'b1;
              arp_cnt    <= CNT_RELOAD;
            end
          end
          MONO, ARP: begin
            if (!held_any) begin
              state      <= IDLE;
              note_valid <= 1'b0;
            end else if (mode_mismatch) begin
              // Mode flip keeps the current note sounding without a re-strike.
              state   <= arp_mode ? ARP : MONO;
              arp_cnt <= CNT_RELOAD;
            end else if (state == MONO) begin
              if (press_any || owner_rel) begin
                note_idx   <= hi_idx;
                note_start <= 1'b1;
              end
            end else begin
              if (owner_rel || (arp_cnt == '0)) begin
                note_idx   <= nx_idx;
                note_start <= 1'b1;
                arp_cnt    <= CNT_RELOAD;
              end else begin
                arp_cnt <= arp_cnt - 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler with a short arpeggio period (ARP_DIV=8).
module tb_note_scheduler;
  import note_scheduler_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             play;
  logic             arp_mode;
  logic [NKEYS-1:0] keys;
  logic [IDX_W-1:0] note_idx;
  logic             note_valid;
  logic             note_start;
  logic             amp_shutdown_n;
  logic             amp_gain;

  int vecs = 0;
  int errs = 0;
  logic [6:0] want;
  logic [2:0] want_flags;

  // {amp_shutdown_n, note_valid, note_start, note_idx}
  wire [6:0] obs = {amp_shutdown_n, note_valid, note_start, note_idx};

  note_scheduler #(.ARP_DIV(8), .GAIN_LVL(1'b1)) dut (
    .clk            (clk),
    .reset          (reset),
    .play           (play),
    .arp_mode       (arp_mode),
    .keys           (keys),
    .note_idx       (note_idx),
    .note_valid     (note_valid),
    .note_start     (note_start),
    .amp_shutdown_n (amp_shutdown_n),
    .amp_gain       (amp_gain)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; play = 1'b1; arp_mode = 1'b0; keys = '0;
    tick(2);
    want = 7'b000_0000;
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL reset_hold: got %b want %b", obs, want); end
    vecs++; if (amp_gain !== 1'b1) begin errs++; $display("[TB] FAIL amp_gain: got %b want 1", amp_gain); end
    reset = 1'b0;
    tick();
    want = {3'b100, 4'd0};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL reset_release: got %b want %b", obs, want); end
  endtask

  task automatic test_mono_last_pressed;
    arp_mode = 1'b0;
    keys = 16'h0008;
    tick();
    want = {3'b111, 4'd3};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL mono_k3: got %b want %b", obs, want); end
    tick();
    want = {3'b110, 4'd3};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL mono_k3_hold: got %b want %b", obs, want); end
    tick(3);
    keys = 16'h0208;
    tick();
    want = {3'b111, 4'd9};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL mono_k9: got %b want %b", obs, want); end
    keys = 16'h0008;
    tick();
    want = {3'b111, 4'd3};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL mono_rel9: got %b want %b", obs, want); end
    keys = '0;
    tick();
    want_flags = 3'b100;
    vecs++; if (obs[6:4] !== want_flags) begin errs++; $display("[TB] FAIL mono_rel3: got %b want %b", obs[6:4], want_flags); end
  endtask

  task automatic test_mono_chord;
    keys = 16'h0084;
    tick();
    want = {3'b111, 4'd7};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL chord_2_7: got %b want %b", obs, want); end
    keys = 16'h0080;
    tick();
    want = {3'b110, 4'd7};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL chord_rel2: got %b want %b", obs, want); end
    keys = '0;
    tick();
    want_flags = 3'b100;
    vecs++; if (obs[6:4] !== want_flags) begin errs++; $display("[TB] FAIL chord_rel7: got %b want %b", obs[6:4], want_flags); end
  endtask

  task automatic test_arp_cycle;
    arp_mode = 1'b1;
    keys = 16'h1022;
    tick();
    want = {3'b111, 4'd12};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL arp_entry: got %b want %b", obs, want); end
    tick(7);
    want = {3'b110, 4'd12};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL arp_wait12: got %b want %b", obs, want); end
    tick();
    want = {3'b111, 4'd1};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL arp_step1: got %b want %b", obs, want); end
    tick(8);
    want = {3'b111, 4'd5};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL arp_step5: got %b want %b", obs, want); end
    tick(3);
    keys = 16'h1002;
    tick();
    want = {3'b111, 4'd12};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL arp_rel5: got %b want %b", obs, want); end
    tick(7);
    want = {3'b110, 4'd12};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL arp_reload: got %b want %b", obs, want); end
    tick();
    want = {3'b111, 4'd1};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL arp_wrap1: got %b want %b", obs, want); end
    keys = 16'h100A;
    tick();
    want = {3'b110, 4'd1};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL arp_join_nopreempt: got %b want %b", obs, want); end
    tick(6);
    tick();
    want = {3'b111, 4'd3};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL arp_join_step3: got %b want %b", obs, want); end
    keys = '0;
    tick();
    want_flags = 3'b100;
    vecs++; if (obs[6:4] !== want_flags) begin errs++; $display("[TB] FAIL arp_empty: got %b want %b", obs[6:4], want_flags); end
  endtask

  task automatic test_arp_single_restrike;
    arp_mode = 1'b1;
    keys = 16'h0040;
    tick();
    want = {3'b111, 4'd6};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL single_entry: got %b want %b", obs, want); end
    tick(8);
    want = {3'b111, 4'd6};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL single_restrike: got %b want %b", obs, want); end
    keys = '0;
    tick();
  endtask

  task automatic test_mode_switch;
    arp_mode = 1'b0;
    keys = 16'h0010;
    tick();
    want = {3'b111, 4'd4};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL sw_mono4: got %b want %b", obs, want); end
    arp_mode = 1'b1;
    tick();
    want = {3'b110, 4'd4};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL sw_to_arp: got %b want %b", obs, want); end
    tick(8);
    want = {3'b111, 4'd4};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL sw_arp_restrike: got %b want %b", obs, want); end
    arp_mode = 1'b0;
    tick();
    want = {3'b110, 4'd4};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL sw_to_mono: got %b want %b", obs, want); end
  endtask

  task automatic test_mute;
    play = 1'b0;
    tick();
    want_flags = 3'b000;
    vecs++; if (obs[6:4] !== want_flags) begin errs++; $display("[TB] FAIL mute_enter: got %b want %b", obs[6:4], want_flags); end
    keys = 16'h0410;
    tick();
    vecs++; if (obs[6:4] !== want_flags) begin errs++; $display("[TB] FAIL mute_ignore10: got %b want %b", obs[6:4], want_flags); end
    tick(2);
    play = 1'b1;
    tick();
    want = {3'b111, 4'd10};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL mute_leave: got %b want %b", obs, want); end
    keys = '0;
    tick();
  endtask

  task automatic test_reset_mid_arp;
    arp_mode = 1'b1;
    keys = 16'h1022;
    tick();
    want = {3'b111, 4'd12};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL rst_arp_entry: got %b want %b", obs, want); end
    tick(2);
    #2 reset = 1'b1;
    #1;
    want = 7'b000_0000;
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL rst_async: got %b want %b", obs, want); end
    #1 reset = 1'b0;
    tick();
    want = {3'b111, 4'd12};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL rst_resume: got %b want %b", obs, want); end
    tick(8);
    want = {3'b111, 4'd1};
    vecs++; if (obs !== want) begin errs++; $display("[TB] FAIL rst_resume_step: got %b want %b", obs, want); end
    keys = '0;
    tick();
  endtask

  initial begin
    reset = 1'b1; play = 1'b1; arp_mode = 1'b0; keys = '0;
    test_reset();
    test_mono_last_pressed();
    test_mono_chord();
    test_arp_cycle();
    test_arp_single_restrike();
    test_mode_switch();
    test_mute();
    test_reset_mid_arp();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
